// File: rtl/reg_dump_ctrl_pkg.sv
// reg_dump_pkg: sequencer state type and default register-bank geometry.
package reg_dump_pkg;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int DATA_W = 32;
    typedef enum logic [1:0] {IDLE, REQ, SEND, DONE} dump_state_t;
endpackage

// File: rtl/reg_dump_ctrl_if.sv
// reg_dump_ctrl_if: control, pre-fetch port and output stream of the register dump sequencer.
interface reg_dump_ctrl_if #(
    parameter int ADDR_W = reg_dump_pkg::ADDR_W,
    parameter int DATA_W = reg_dump_pkg::DATA_W
);
    logic              start;
    logic [ADDR_W-1:0] lo_addr;
    logic [ADDR_W-1:0] hi_addr;
    logic              pf_en;
    logic [31:0]       pf_addr;
    logic [DATA_W-1:0] pf_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, lo_addr, hi_addr, pf_data, out_ready,
        output pf_en, pf_addr, out_valid, out_addr, out_data, out_last, busy, done, err
    );

    modport slave (
        output start, lo_addr, hi_addr, pf_data, out_ready,
        input  pf_en, pf_addr, out_valid, out_addr, out_data, out_last, busy, done, err
    );
endinterface

// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: walks a register range through the pre-fetch port and streams {addr, data} pairs.
module reg_dump_ctrl #(
    parameter int NUM_REGS = reg_dump_pkg::NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int DATA_W   = reg_dump_pkg::DATA_W,
    parameter bit ZERO_R0  = 1'b1
) (
    input logic             clk,
    input logic             rst,
    reg_dump_ctrl_if.master bus
);
    import reg_dump_pkg::*;

    dump_state_t       state, nxt;
    logic [ADDR_W-1:0] cur, hi;
    logic              accept, reject;

    assign accept = state == IDLE && bus.start && bus.lo_addr <= bus.hi_addr;
    assign reject = state == IDLE && bus.start && bus.lo_addr > bus.hi_addr;

    // pf_* decode purely from registers so the bank sees no input-to-output path
    assign bus.pf_en     = state == REQ;
    assign bus.pf_addr   = bus.pf_en ? 32'(cur) : 32'd0;
    assign bus.out_valid = state == SEND;
    assign bus.busy      = state != IDLE;
    assign bus.done      = state == DONE;

    always_comb begin
        nxt = state;
        nxt = state == IDLE ? (accept ? REQ : IDLE) :
              state == REQ  ? SEND :
              state == SEND ? (bus.out_ready ? (bus.out_last ? DONE : REQ) : SEND) :
                              IDLE;
    end

    // termination rides on out_last, so cur stops at hi and never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cur          <= '0;
            hi           <= '0;
            bus.out_addr <= '0;
            bus.out_data <= '0;
            bus.out_last <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            state   <= nxt;
            bus.err <= reject;
            if (accept) begin
                cur <= bus.lo_addr;
                hi  <= bus.hi_addr;
            end
            if (bus.pf_en) begin
                bus.out_data <= (ZERO_R0 && cur == '0) ? '0 : bus.pf_data;
                bus.out_addr <= cur;
                bus.out_last <= cur == hi;
            end
            if (state == SEND && bus.out_ready && !bus.out_last)
                cur <= cur + 1'b1;
        end
    end
endmodule
